puf_parallel_vote: RTL and testbench

PUF_PARALLEL_VOTE -- requirements
Module: puf_parallel_vote

---
 rtl/puf_pkg.sv | 16 +
 rtl/puf_vote_acc.sv | 28 ++
 rtl/puf_parallel_vote.sv | 118 +++++++++++
 tb/tb_puf_parallel_vote.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state, default parameters and counter-width helper for the PUF vote block
package puf_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT, ACCUM, DONE} state_t;

    localparam int N_CH_DEF        = 8;
    localparam int CHAL_W_DEF      = 8;
    localparam int EN_W_DEF        = 32;
    localparam int N_EVAL_DEF      = 5;
    localparam int TIMEOUT_CYC_DEF = 1024;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_vote_acc.sv
// puf_vote_acc: one channel's vote counter with majority and unanimity compares
module puf_vote_acc
    import puf_pkg::*;
#(
    parameter int N_EVAL = N_EVAL_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic maj,
    output logic unan
);

    localparam int CW = cnt_w(N_EVAL);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign maj  = cnt > CW'(N_EVAL / 2);
    assign unan = cnt == '0 || cnt == CW'(N_EVAL);

endmodule

// File: rtl/puf_parallel_vote.sv
// puf_parallel_vote: runs N_EVAL PUF evaluations over N_CH channels and majority-votes each bit.
// Define PUF_VOTE_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT_CYC cycles.
module puf_parallel_vote
    import puf_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int CHAL_W      = CHAL_W_DEF,
    parameter int EN_W        = EN_W_DEF,
    parameter int N_EVAL      = N_EVAL_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    input  logic [EN_W-1:0]   enable_cfg,
    output logic              ready,
    output logic [CHAL_W-1:0] ch_challenge,
    output logic [EN_W-1:0]   ch_enable,
    output logic              ch_clear,
    input  logic [N_CH-1:0]   ch_done,
    input  logic [N_CH-1:0]   ch_out,
    output logic [N_CH-1:0]   resp,
    output logic [N_CH-1:0]   stable_mask,
    output logic              resp_valid,
    input  logic              resp_ack,
    output logic              timeout_err
);

    localparam int CW = cnt_w(N_EVAL);

    state_t            state, state_nxt;
    logic [CHAL_W-1:0] chal_q;
    logic [EN_W-1:0]   en_q;
    logic [CW-1:0]     eval_cnt;
    logic              res_ok, tout_q, accept, all_done, last_eval, tmo;
    logic [N_CH-1:0]   maj, unan;

    assign accept    = state == IDLE && start;
    assign all_done  = &ch_done;
    assign last_eval = eval_cnt == CW'(N_EVAL - 1);

`ifdef PUF_VOTE_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT_CYC);
    logic [TW-1:0] timer;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              timer <= '0;
        else if (state == CLEAR) timer <= '0;
        else if (state == WAIT)  timer <= timer + 1'b1;
    end
    assign tmo = state == WAIT && !all_done && timer == TW'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CLEAR : IDLE;
            CLEAR:   state_nxt = WAIT;
            WAIT:    state_nxt = all_done ? ACCUM : tmo ? DONE : WAIT;
            ACCUM:   state_nxt = last_eval ? DONE : CLEAR;
            DONE:    state_nxt = resp_ack ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // res_ok gates the vote compares so results appear only after a completed run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chal_q   <= '0;
            en_q     <= '0;
            eval_cnt <= '0;
            res_ok   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            if (accept) begin
                chal_q   <= challenge;
                en_q     <= enable_cfg;
                eval_cnt <= '0;
                res_ok   <= 1'b0;
                tout_q   <= 1'b0;
            end
            if (state == ACCUM) eval_cnt <= eval_cnt + 1'b1;
            if (state == ACCUM && last_eval) res_ok <= 1'b1;
            if (tmo) tout_q <= 1'b1;
        end
    end

    always_comb begin
        ready      = state == IDLE;
        ch_clear   = state == CLEAR;
        ch_enable  = state == WAIT ? en_q : '0;
        resp_valid = state == DONE;
    end

    assign ch_challenge = chal_q;
    assign resp         = res_ok ? maj : '0;
    assign stable_mask  = res_ok ? unan : '0;
    assign timeout_err  = tout_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_acc
        puf_vote_acc #(.N_EVAL(N_EVAL)) u_acc (
            .clock(clock),
            .reset(reset),
            .clr  (accept),
            .inc  (state == ACCUM && ch_out[i]),
            .maj  (maj[i]),
            .unan (unan[i])
        );
    end

endmodule

// File: tb/tb_puf_parallel_vote.sv
// tb_puf_parallel_vote: table-driven and scoreboard checks of puf_parallel_vote (default and 16-channel single-eval builds)
module tb_puf_parallel_vote;

    typedef struct {
        logic [7:0]       chal;
        logic [31:0]      en;
        logic [0:4][7:0]  seq;
        int               dat;
        logic [7:0]       resp;
        logic [7:0]       stab;
    } vec_t;

    typedef struct {
        logic [15:0] resp;
        logic [15:0] stab;
        logic        tout;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        start_a = 1'b0, ack_a = 1'b0;
    logic [7:0]  chal_a = '0;
    logic [31:0] en_a = '0;
    logic        ready_a, chclr_a, valid_a, tout_a;
    logic [7:0]  chch_a, chdone_a, chout_a, resp_a, stab_a;
    logic [31:0] chen_a;

    logic        start_b = 1'b0, ack_b = 1'b0;
    logic [7:0]  chal_b = '0;
    logic [31:0] en_b = '0;
    logic        ready_b, chclr_b, valid_b, tout_b;
    logic [7:0]  chch_b;
    logic [15:0] chdone_b, chout_b, resp_b, stab_b;
    logic [31:0] chen_b;

    puf_parallel_vote u_a (
        .clock(clock), .reset(reset), .start(start_a), .challenge(chal_a), .enable_cfg(en_a),
        .ready(ready_a), .ch_challenge(chch_a), .ch_enable(chen_a), .ch_clear(chclr_a),
        .ch_done(chdone_a), .ch_out(chout_a), .resp(resp_a), .stable_mask(stab_a),
        .resp_valid(valid_a), .resp_ack(ack_a), .timeout_err(tout_a)
    );

    puf_parallel_vote #(.N_CH(16), .N_EVAL(1), .TIMEOUT_CYC(16)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .challenge(chal_b), .enable_cfg(en_b),
        .ready(ready_b), .ch_challenge(chch_b), .ch_enable(chen_b), .ch_clear(chclr_b),
        .ch_done(chdone_b), .ch_out(chout_b), .resp(resp_b), .stable_mask(stab_b),
        .resp_valid(valid_b), .resp_ack(ack_b), .timeout_err(tout_b)
    );

    // channel models: done after dat WAIT cycles, response bits chosen per evaluation
    int          wc_a, ec_a, wc_b;
    int          dat_a = 3, dat_b = 1;
    logic [7:0]  seq_a [8];
    logic [7:0]  dmask_a = 8'hFF;
    logic [15:0] out_b = '0, dmask_b = 16'hFFFF;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            wc_a <= 0;
            ec_a <= 0;
            wc_b <= 0;
        end else begin
            wc_a <= chclr_a ? 0 : chen_a != 0 ? wc_a + 1 : wc_a;
            ec_a <= ready_a ? 0 : ec_a + int'(chclr_a);
            wc_b <= chclr_b ? 0 : chen_b != 0 ? wc_b + 1 : wc_b;
        end
    end

    assign chdone_a = (chen_a != 0 && wc_a + 1 >= dat_a) ? dmask_a : 8'h00;
    assign chout_a  = seq_a[ec_a[2:0]];
    assign chdone_b = (chen_b != 0 && wc_b + 1 >= dat_b) ? dmask_b : 16'h0000;
    assign chout_b  = out_b;

    int   n_chk = 0, n_pass = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic check_out(input string p, input logic [15:0] r, input logic [15:0] s,
                             input logic t, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({p, "_sb_empty"}, 32'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        chk({p, "_resp"}, 32'(r), 32'(e.resp));
        chk({p, "_stable"}, 32'(s), 32'(e.stab));
        chk({p, "_timeout"}, 32'(t), 32'(e.tout));
        chk({p, "_latency"}, 32'(lat), 32'(e.lat));
    endtask

    task automatic push_exp(input logic [15:0] r, input logic [15:0] s, input logic t, input int lat);
        exp_t e;
        e.resp = r;
        e.stab = s;
        e.tout = t;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic run_a(input vec_t v);
        int lat;
        logic [31:0] seen_en;
        for (int k = 0; k < 5; k++) seq_a[k+1] = v.seq[k];
        dat_a = v.dat; chal_a = v.chal; en_a = v.en; start_a = 1'b1;
        push_exp(16'(v.resp), 16'(v.stab), 1'b0, 5 * (v.dat + 2) + 1);
        @(posedge clock); #1;
        start_a = 1'b0; lat = 1; seen_en = '0;
        chk("a_clear", 32'(chclr_a), 1);
        chk("a_chal", 32'(chch_a), 32'(v.chal));
        while (!valid_a && lat < 400) begin
            @(posedge clock); #1;
            lat++;
            if (chen_a != 0) seen_en = chen_a;
        end
        chk("a_enable", seen_en, v.en);
        check_out("a", 16'(resp_a), 16'(stab_a), tout_a, lat);
        ack_a = 1'b1;
        @(posedge clock); #1;
        ack_a = 1'b0;
        chk("a_ready_after_ack", 32'({ready_a, valid_a}), 32'b10);
    endtask

    task automatic run_b(input logic [7:0] c, input logic [15:0] o, input int d,
                         input logic [15:0] r, input logic [15:0] s, input logic t, input int el);
        int lat;
        out_b = o; dat_b = d; chal_b = c; en_b = 32'h0000_FFFF; start_b = 1'b1;
        push_exp(r, s, t, el);
        @(posedge clock); #1;
        start_b = 1'b0; lat = 1;
        chk("b_chal", 32'(chch_b), 32'(c));
        while (!valid_b && lat < 400) begin
            @(posedge clock); #1;
            lat++;
        end
        check_out("b", resp_b, stab_b, tout_b, lat);
        ack_b = 1'b1;
        @(posedge clock); #1;
        ack_b = 1'b0;
        chk("b_ready_after_ack", 32'(ready_b), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        vec_t r;
        vecs[0] = '{8'h01, 32'hFFFF_FFFF, {5{8'hA5}},                      3, 8'hA5, 8'hFF};
        vecs[1] = '{8'h02, 32'h0000_00FF, {8'h01, 8'h00, 8'h01, 8'h00, 8'h01}, 3, 8'h01, 8'hFE};
        vecs[2] = '{8'h03, 32'h8000_0001, {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, 1, 8'h00, 8'h00};
        vecs[3] = '{8'hC3, 32'h1234_5678, {8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F}, 2, 8'hF0, 8'h00};
        vecs[4] = '{8'hFE, 32'h0000_0100, {8'h81, 8'h81, 8'h81, 8'h81, 8'h80}, 4, 8'h81, 8'hFE};
        vecs[5] = '{8'h00, 32'h0000_0001, {5{8'h00}},                      5, 8'h00, 8'hFF};
        for (int k = 0; k < 8; k++) seq_a[k] = '0;

        @(posedge clock); #1;
        chk("rst_ready", 32'(ready_a), 1);
        chk("rst_resp", 32'(resp_a), 0);
        chk("rst_stable", 32'(stab_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_timeout", 32'(tout_a), 0);
        chk("rst_chal", 32'(chch_a), 0);
        chk("rst_enable", chen_a, 0);
        chk("rst_clear", 32'(chclr_a), 0);
        chk("rst_b_stable", 32'(stab_b), 0);
        reset = 1'b1;

        foreach (vecs[i]) run_a(vecs[i]);

        // start pulses in WAIT and DONE must be ignored; result held until ack
        for (int k = 1; k <= 5; k++) seq_a[k] = 8'hA5;
        dat_a = 3; chal_a = 8'h5A; en_a = 32'hFFFF_FFFF; start_a = 1'b1;
        push_exp(16'h00A5, 16'h00FF, 1'b0, 26);
        @(posedge clock); #1;
        start_a = 1'b0; lat = 1;
        while (chen_a == 0 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        start_a = 1'b1; chal_a = 8'hFF;
        @(posedge clock); #1;
        start_a = 1'b0; lat++;
        chk("wait_start_ignored", 32'(chch_a), 32'h5A);
        while (!valid_a && lat < 400) begin
            @(posedge clock); #1;
            lat++;
        end
        check_out("ign", 16'(resp_a), 16'(stab_a), tout_a, lat);
        start_a = 1'b1; chal_a = 8'h77;
        @(posedge clock); #1;
        start_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("done_hold", 32'({valid_a, ready_a, chch_a}), 32'({1'b1, 1'b0, 8'h5A}));
            @(posedge clock); #1;
        end
        ack_a = 1'b1;
        @(posedge clock); #1;
        ack_a = 1'b0;
        chk("ack_ready", 32'({ready_a, valid_a}), 32'b10);
        chk("ack_resp_hold", 32'({resp_a, stab_a, chch_a}), 32'h00A5_FF5A);
        @(posedge clock); #1;
        chk("no_queued_start", 32'(ready_a), 1);

        // asynchronous reset in the second WAIT cycle, then immediate restart
        for (int k = 1; k <= 5; k++) seq_a[k] = 8'hFF;
        dat_a = 3; chal_a = 8'h11; start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_enable", chen_a, 32'hFFFF_FFFF);
        reset = 1'b0;
        #1;
        chk("mid_reset_state", 32'({ready_a, chclr_a, valid_a, chch_a}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));
        chk("mid_reset_enable", chen_a, 0);
        #1;
        reset = 1'b1;
        r = '{8'h3C, 32'hFFFF_FFFF, {5{8'hA5}}, 3, 8'hA5, 8'hFF};
        run_a(r);

        // single-evaluation 16-channel build
        run_b(8'h21, 16'hBEEF, 1, 16'hBEEF, 16'hFFFF, 1'b0, 4);
        run_b(8'h22, 16'h0001, 2, 16'h0001, 16'hFFFF, 1'b0, 5);

        // channel 3 never completes
        dmask_b = 16'hFFF7;
`ifdef PUF_VOTE_TIMEOUT_EN
        run_b(8'h42, 16'hFFFF, 1, 16'h0000, 16'h0000, 1'b1, 18);
`else
        chal_b = 8'h42; out_b = 16'hFFFF; start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        chk("no_tmo_valid", 32'(valid_b), 0);
        chk("no_tmo_err", 32'(tout_b), 0);
        chk("no_tmo_waiting", 32'(chen_b != 0), 1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
`endif
        dmask_b = 16'hFFFF;
        run_b(8'h43, 16'h1234, 1, 16'h1234, 16'hFFFF, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
